// File: rtl/m107_pkg.sv
// Shared types for the M107 video path: pixel format, palette FSM states
// and the 5-bit to RGB_W colour expansion helper.
package m107_pkg;

    typedef struct packed {
        logic [6:0] pal;
        logic [3:0] pen;
    } pix_t;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RD
    } pal_st_t;

    // Replicates the 5-bit value MSB-first until w bits are filled.
    function automatic logic [31:0] expand5(input logic [4:0] v, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < w && i < 32; i++) begin
            r[5'(w - 1 - i)] = v[3'(4 - (i % 5))];
        end
        return r;
    endfunction

endpackage

// File: rtl/m107_pal_ram.sv
// Single-port palette RAM with synchronous read; a write returns the
// previous contents of the addressed word.
module m107_pal_ram
    import m107_pkg::*;
#(
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   din,
    output logic [15:0]   q
);

    logic [15:0] mem [0:(1 << AW) - 1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/m107_pal_mixer.sv
// Tile/sprite priority mixer with palette lookup and the CPU palette window;
// the RAM port is time-shared between pixel reads and CPU accesses.
module m107_pal_mixer
    import m107_pkg::*;
#(
    parameter int unsigned PAL_AW = 11,
    parameter int unsigned RGB_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic [10:0]       tile_color,
    input  logic              tile_prio,
    input  logic              color_blank,
    input  logic [10:0]       spr_color,
    input  logic              spr_prio,
    input  logic              pal_cs,
    input  logic              pal_rd,
    input  logic              pal_wr,
    input  logic [PAL_AW-1:0] addr,
    input  logic [15:0]       cpu_din,
    output logic [15:0]       cpu_dout,
    output logic              busy,
    output logic [RGB_W-1:0]  red,
    output logic [RGB_W-1:0]  green,
    output logic [RGB_W-1:0]  blue
);

    pix_t              tile_px, spr_px, sel_px;
    logic [10:0]       idx;
    logic              blk_d, pix_slot, pix_done;
    logic [14:0]       pix_q;
    logic [15:0]       q;
    logic [RGB_W-1:0]  red_nx, green_nx, blue_nx;

    pal_st_t           state, state_nx;
    logic              req, req_d, accept, cpu_issue;
    logic              lat_we;
    logic [15:0]       lat_din;
    logic [PAL_AW-1:0] lat_addr;

    logic              ram_en, ram_we;
    logic [PAL_AW-1:0] ram_addr;

    always_comb begin
        tile_px = pix_t'(tile_color);
        spr_px  = pix_t'(spr_color);
        sel_px  = tile_px;
        if ((|spr_px.pen) && (spr_prio || !tile_prio)) begin
            sel_px = spr_px;
        end
    end

    always_comb begin
        red_nx   = RGB_W'(expand5(pix_q[4:0], RGB_W));
        green_nx = RGB_W'(expand5(pix_q[9:5], RGB_W));
        blue_nx  = RGB_W'(expand5(pix_q[14:10], RGB_W));
    end

    // pix_q is captured the clk after the PIXEL-slot read, before a CPU
    // access in the free slot can overwrite the shared RAM output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= '0;
            blk_d    <= 1'b0;
            pix_slot <= 1'b0;
            pix_done <= 1'b0;
            pix_q    <= '0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else begin
            pix_slot <= ce_pix;
            pix_done <= pix_slot;
            if (pix_done) begin
                pix_q <= q[14:0];
            end
            if (ce_pix) begin
                idx   <= sel_px;
                blk_d <= color_blank;
                if (blk_d) begin
                    red   <= '0;
                    green <= '0;
                    blue  <= '0;
                end else begin
                    red   <= red_nx;
                    green <= green_nx;
                    blue  <= blue_nx;
                end
            end
        end
    end

    assign req    = pal_cs & (pal_rd | pal_wr);
    assign accept = req & ~req_d & (state == IDLE);
    assign busy   = (state != IDLE);

    always_comb begin
        state_nx  = state;
        cpu_issue = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = PEND;
                end
            end
            PEND: begin
                if (!pix_slot && !ce_pix) begin
                    cpu_issue = 1'b1;
                    state_nx  = lat_we ? IDLE : RD;
                end
            end
            RD:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            req_d    <= 1'b0;
            lat_we   <= 1'b0;
            lat_din  <= '0;
            lat_addr <= '0;
            cpu_dout <= '0;
        end else begin
            state <= state_nx;
            req_d <= req;
            if (accept) begin
                lat_we   <= pal_wr;
                lat_din  <= cpu_din;
                lat_addr <= addr;
            end
            if (state == RD) begin
                cpu_dout <= q;
            end
        end
    end

    assign ram_en   = cpu_issue | pix_slot;
    assign ram_we   = cpu_issue & lat_we;
    assign ram_addr = cpu_issue ? lat_addr : PAL_AW'(idx);

    m107_pal_ram #(
        .AW(PAL_AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (lat_din),
        .q    (q)
    );

endmodule

// File: tb/tb_m107_pal_mixer.sv
// Directed bench for m107_pal_mixer: table-driven mix vectors plus
// hand-aligned CPU/pixel timing sequences.
module tb_m107_pal_mixer;

    logic        clk;
    logic        reset_n;
    logic        ce_pix;
    logic [10:0] tile_color;
    logic        tile_prio;
    logic        color_blank;
    logic [10:0] spr_color;
    logic        spr_prio;
    logic        pal_cs, pal_rd, pal_wr;
    logic [10:0] addr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        busy;
    logic [7:0]  red, green, blue;

    int          total = 0;
    int          bad   = 0;
    logic        ce_run;
    logic        ce_hit;
    int          ph;
    logic [15:0] rdata;

    typedef struct {
        logic [10:0] tc;
        logic        tp;
        logic        blank;
        logic [10:0] sc;
        logic        sp;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs [9];

    m107_pal_mixer #(
        .PAL_AW(11),
        .RGB_W (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce_pix      (ce_pix),
        .tile_color  (tile_color),
        .tile_prio   (tile_prio),
        .color_blank (color_blank),
        .spr_color   (spr_color),
        .spr_prio    (spr_prio),
        .pal_cs      (pal_cs),
        .pal_rd      (pal_rd),
        .pal_wr      (pal_wr),
        .addr        (addr),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .busy        (busy),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; ce_pix is asserted for every third edge while ce_run is set.
    task automatic step();
        @(posedge clk);
        ce_hit = ce_pix;
        #1;
        if (ce_run) begin
            ph     = (ph == 2) ? 0 : ph + 1;
            ce_pix = (ph == 0);
        end else begin
            ce_pix = 1'b0;
        end
    endtask

    task automatic wait_ce();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!ce_hit && n < 10);
        if (!ce_hit) begin
            total++;
            bad++;
            $display("FAIL ce_timeout: got no ce_pix edge within %0d clk", n);
        end
    endtask

    task automatic cpu_access(input logic wr, input logic [10:0] a, input logic [15:0] d,
                              output logic [15:0] rd);
        int n;
        pal_cs  = 1'b1;
        pal_wr  = wr;
        pal_rd  = !wr;
        addr    = a;
        cpu_din = d;
        step();
        chk("busy_set", busy, 1);
        n = 0;
        while (busy && n < 8) begin
            step();
            n++;
        end
        total++;
        if (busy || n > 4) begin
            bad++;
            $display("FAIL busy_len: got %0d clk (busy=%0b) expected <=4 and clear", n, busy);
        end
        rd     = cpu_dout;
        pal_cs = 1'b0;
        pal_wr = 1'b0;
        pal_rd = 1'b0;
        step();
    endtask

    initial begin
        vecs[0] = '{11'h012, 1'b1, 1'b0, 11'h021, 1'b0, 24'hFFFFFF};
        vecs[1] = '{11'h012, 1'b1, 1'b0, 11'h021, 1'b1, 24'hFF0000};
        vecs[2] = '{11'h012, 1'b1, 1'b0, 11'h020, 1'b1, 24'hFFFFFF};
        vecs[3] = '{11'h012, 1'b0, 1'b0, 11'h021, 1'b0, 24'hFF0000};
        vecs[4] = '{11'h055, 1'b0, 1'b0, 11'h050, 1'b1, 24'h00FF00};
        vecs[5] = '{11'h0A0, 1'b0, 1'b0, 11'h000, 1'b0, 24'h0000FF};
        vecs[6] = '{11'h012, 1'b0, 1'b1, 11'h021, 1'b1, 24'h000000};
        vecs[7] = '{11'h0B0, 1'b0, 1'b0, 11'h000, 1'b0, 24'h848484};
        vecs[8] = '{11'h0C0, 1'b1, 1'b0, 11'h0C0, 1'b1, 24'h080808};

        reset_n     = 1'b0;
        ce_pix      = 1'b0;
        ce_run      = 1'b0;
        ce_hit      = 1'b0;
        ph          = 0;
        tile_color  = '0;
        tile_prio   = 1'b0;
        color_blank = 1'b0;
        spr_color   = '0;
        spr_prio    = 1'b0;
        pal_cs      = 1'b0;
        pal_rd      = 1'b0;
        pal_wr      = 1'b0;
        addr        = '0;
        cpu_din     = '0;

        repeat (3) step();
        chk("reset_rgb", {red, green, blue}, 24'h0);
        chk("reset_busy", busy, 0);
        chk("reset_dout", cpu_dout, 16'h0);
        reset_n = 1'b1;
        step();

        cpu_access(1'b1, 11'h012, 16'h7FFF, rdata);
        cpu_access(1'b1, 11'h021, 16'h001F, rdata);
        cpu_access(1'b1, 11'h055, 16'h03E0, rdata);
        cpu_access(1'b1, 11'h0A0, 16'hFC00, rdata);
        cpu_access(1'b1, 11'h0B0, 16'h4210, rdata);
        cpu_access(1'b1, 11'h0C0, 16'h0421, rdata);
        cpu_access(1'b1, 11'h030, 16'h001F, rdata);
        cpu_access(1'b0, 11'h012, 16'h0000, rdata);
        chk("rd_012", rdata, 16'h7FFF);
        cpu_access(1'b0, 11'h0A0, 16'h0000, rdata);
        chk("rd_bit15", rdata, 16'hFC00);

        ce_run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tile_color  = vecs[i].tc;
            tile_prio   = vecs[i].tp;
            color_blank = vecs[i].blank;
            spr_color   = vecs[i].sc;
            spr_prio    = vecs[i].sp;
            wait_ce();
            if (i > 0) chk($sformatf("latency%0d", i), {red, green, blue}, vecs[i-1].rgb);
            wait_ce();
            chk($sformatf("mix%0d", i), {red, green, blue}, vecs[i].rgb);
        end

        // Collision: write the displayed entry in the free slot after a PIXEL read.
        tile_color  = 11'h030;
        tile_prio   = 1'b0;
        color_blank = 1'b0;
        spr_color   = 11'h000;
        spr_prio    = 1'b0;
        repeat (3) wait_ce();
        chk("coll_before", {red, green, blue}, 24'hFF0000);
        pal_cs  = 1'b1;
        pal_wr  = 1'b1;
        addr    = 11'h030;
        cpu_din = 16'h7C00;
        step();
        chk("coll_busy_set", busy, 1);
        pal_cs = 1'b0;
        pal_wr = 1'b0;
        step();
        chk("coll_busy_clr", busy, 0);
        chk("coll_noglitch", {red, green, blue}, 24'hFF0000);
        wait_ce();
        chk("coll_old", {red, green, blue}, 24'hFF0000);
        wait_ce();
        chk("coll_new", {red, green, blue}, 24'h0000FF);

        // Busy ignore: accept just before a ce/PIXEL pair so the write stays pending.
        wait_ce();
        step();
        pal_cs  = 1'b1;
        pal_wr  = 1'b1;
        addr    = 11'h0D0;
        cpu_din = 16'h1111;
        step();
        chk("ign_busy_acc", busy, 1);
        pal_cs = 1'b0;
        pal_wr = 1'b0;
        step();
        chk("ign_busy_held", busy, 1);
        pal_cs  = 1'b1;
        pal_wr  = 1'b1;
        cpu_din = 16'h2222;
        step();
        chk("ign_busy_rise", busy, 1);
        step();
        chk("ign_done", busy, 0);
        step();
        chk("ign_no_reaccept", busy, 0);
        pal_cs = 1'b0;
        pal_wr = 1'b0;
        step();
        cpu_access(1'b0, 11'h0D0, 16'h0000, rdata);
        chk("ign_one_write", rdata, 16'h1111);

        // Reset while a write is still pending: it must be dropped.
        cpu_access(1'b0, 11'h021, 16'h0000, rdata);
        chk("rd_021", rdata, 16'h001F);
        wait_ce();
        step();
        pal_cs  = 1'b1;
        pal_wr  = 1'b1;
        addr    = 11'h021;
        cpu_din = 16'h1234;
        step();
        chk("rst_pend_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_rgb", {red, green, blue}, 24'h0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_dout", cpu_dout, 16'h0);
        pal_cs = 1'b0;
        pal_wr = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        cpu_access(1'b0, 11'h021, 16'h0000, rdata);
        chk("rst_dropped", rdata, 16'h001F);
        wait_ce();
        wait_ce();
        chk("rst_recover", {red, green, blue}, 24'h0000FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
